mem_port_arbiter: RTL

//  Shares one Memory instance (cmd/addr/rdata handshake) between two requesters:

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory command/read-data port between instruction fetch
// (port 0) and data access (port 1), with one outstanding read and a read timeout.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter bit FIXED_PRIORITY = 1'b0,
  parameter int RD_TIMEOUT     = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [1:0]              i_req_cmd_start,
  input  logic [1:0]              i_req_cmd_write,
  output logic [1:0]              o_req_cmd_ready,
  input  logic [2*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [2*DATA_WIDTH-1:0] i_req_wdata,
  input  logic [2*DATA_WIDTH-1:0] i_req_wmask,
  output logic [DATA_WIDTH-1:0]   o_req_rdata,
  output logic [1:0]              o_req_rdata_ready,
  output logic                    o_mem_cmd_start,
  output logic                    o_mem_cmd_write,
  input  logic                    i_mem_cmd_ready,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH-1:0]   o_mem_wmask,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  input  logic                    i_mem_rdata_ready,
  output logic                    o_rd_owner,
  output logic                    o_busy,
  output logic                    o_rd_timeout
);

  localparam int            TW       = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);
  localparam bit            TMO_EN   = (RD_TIMEOUT != 0);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_WAIT_RD = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_rd_owner;
  logic          r_last_grant;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_rd_timeout;
  logic          w_winner;
  logic          w_sel_start;
  logic          w_accept;
  logic          w_tmo_hit;

  // Winner selection: a lone requester wins; a tie goes to port 0 or alternates.
  always_comb begin
    w_winner = 1'b0;
    case (i_req_cmd_start)
      2'b01:   w_winner = 1'b0;
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = FIXED_PRIORITY ? 1'b0 : ~r_last_grant;
      default: w_winner = 1'b0;
    endcase
  end

  assign w_sel_start     = w_winner ? i_req_cmd_start[1] : i_req_cmd_start[0];
  assign o_mem_cmd_write = w_winner ? i_req_cmd_write[1] : i_req_cmd_write[0];
  assign o_mem_addr      = w_winner ? i_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                    : i_req_addr[ADDR_WIDTH-1:0];
  assign o_mem_wdata     = w_winner ? i_req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                    : i_req_wdata[DATA_WIDTH-1:0];
  assign o_mem_wmask     = w_winner ? i_req_wmask[2*DATA_WIDTH-1:DATA_WIDTH]
                                    : i_req_wmask[DATA_WIDTH-1:0];
  assign o_req_rdata     = i_mem_rdata;

  assign w_accept  = (r_state == S_IDLE) && w_sel_start && i_mem_cmd_ready;
  // Data arriving on the last allowed cycle beats the timeout.
  assign w_tmo_hit = TMO_EN && (r_tmo_cnt == TMO_LAST) && !i_mem_rdata_ready;

  // State and bookkeeping registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_rd_owner   <= 1'b0;
      r_last_grant <= 1'b1;
      r_tmo_cnt    <= '0;
      r_rd_timeout <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd_timeout <= (r_state == S_WAIT_RD) && w_tmo_hit;
      if (w_accept) begin
        r_last_grant <= w_winner;
        if (!o_mem_cmd_write) begin
          r_rd_owner <= w_winner;
          r_tmo_cnt  <= '0;
        end
      end else if ((r_state == S_WAIT_RD) && !i_mem_rdata_ready) begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !o_mem_cmd_write) w_state_nxt = S_WAIT_RD;
        else                              w_state_nxt = S_IDLE;
      end
      S_WAIT_RD: begin
        if (i_mem_rdata_ready || w_tmo_hit) w_state_nxt = S_IDLE;
        else                                w_state_nxt = S_WAIT_RD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs; everything is held low while reset is asserted.
  always_comb begin
    o_mem_cmd_start   = 1'b0;
    o_req_cmd_ready   = 2'b00;
    o_req_rdata_ready = 2'b00;
    if (!i_rst && (r_state == S_IDLE)) begin
      o_mem_cmd_start           = w_sel_start;
      o_req_cmd_ready[w_winner] = i_mem_cmd_ready;
    end else if (!i_rst && (r_state == S_WAIT_RD)) begin
      o_req_rdata_ready[r_rd_owner] = i_mem_rdata_ready;
    end else begin
      o_mem_cmd_start   = 1'b0;
      o_req_cmd_ready   = 2'b00;
      o_req_rdata_ready = 2'b00;
    end
  end

  assign o_rd_owner   = r_rd_owner;
  assign o_busy       = (r_state == S_WAIT_RD);
  assign o_rd_timeout = r_rd_timeout;

endmodule
